// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the CPU run-control logic: run-state encoding,
// debug-bus source selects and the status-word packing helper.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        RESET_HOLD = 2'd0,
        RUN        = 2'd1,
        HALTED     = 2'd2,
        STEP       = 2'd3
    } run_state_t;

    localparam logic [1:0] DBG_CYCLES   = 2'd0;
    localparam logic [1:0] DBG_HALT_PC  = 2'd1;
    localparam logic [1:0] DBG_HALT_CNT = 2'd2;
    localparam logic [1:0] DBG_STATUS   = 2'd3;

    // Status word layout: {28'b0, bp_skip, halted, state}
    function automatic logic [31:0] status_word(input logic       bp_skip,
                                                input logic       halted,
                                                input run_state_t st);
        return {28'b0, bp_skip, halted, st};
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector. The previous-level register resets to
// RST_VAL, so a level already high at reset release produces no edge when
// RST_VAL is 1.
module rise_detect #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,   // synchronous, active-low
    input  logic d_i,
    output logic rise_o
);

    logic d_q;

    // Track the previous level of the input.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            d_q <= RST_VAL;
        end else begin
            d_q <= d_i;
        end
    end

    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer for the CPU core: gates the core advance enable,
// holds the core idle after reset, stops on HALT or a PC breakpoint and
// resumes (free-run or single step) on a rising edge of continue_i.
// Also owns the cycle/halt counters and the registered 32-bit debug bus.
// Optional feature macro: RUN_CTRL_BREAKPOINT_EN enables the PC breakpoint
// comparator and the resume skip flag; without it bp_addr_i/bp_valid_i are
// unused and no breakpoint ever fires.
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int RESET_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,        // synchronous, active-low
    input  logic        continue_i,
    input  logic        step_mode_i,
    input  logic        halt_req_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] bp_addr_i,
    input  logic        bp_valid_i,
    input  logic [1:0]  dbg_sel_i,
    output logic        cpu_en_o,
    output logic        halted_o,
    output logic [31:0] debug_o
);

    localparam logic [7:0] HOLD_LAST = 8'(RESET_CYCLES - 1);

    run_state_t       state_q, state_d;
    logic [7:0]       hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] halt_cnt_q, halt_cnt_d;
    logic [31:0]      halt_pc_q, halt_pc_d;
    logic [31:0]      debug_q, debug_d;

    logic cont_rise;
    logic bp_hit;
    logic bp_skip;
    logic cpu_en;
    logic halted;
    logic halt_event;

    rise_detect #(
        .RST_VAL (1'b1)
    ) u_cont_rise (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .d_i    (continue_i),
        .rise_o (cont_rise)
    );

`ifdef RUN_CTRL_BREAKPOINT_EN
    logic bp_skip_q, bp_skip_d;

    // Arm the skip flag when leaving HALTED so the resumed instruction at the
    // breakpoint PC is not re-hit; drop it once the core has advanced.
    always_comb begin
        bp_skip_d = bp_skip_q;
        if (state_q == HALTED && state_d != HALTED) begin
            bp_skip_d = 1'b1;
        end else if (cpu_en) begin
            bp_skip_d = 1'b0;
        end
    end

    // Skip-flag register.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            bp_skip_q <= 1'b0;
        end else begin
            bp_skip_q <= bp_skip_d;
        end
    end

    assign bp_skip = bp_skip_q;
    assign bp_hit  = bp_valid_i & (pc_i == bp_addr_i) & ~bp_skip_q;
`else
    logic unused_bp;
    assign unused_bp = ^{bp_addr_i, bp_valid_i};
    assign bp_skip   = 1'b0;
    assign bp_hit    = 1'b0;
`endif

    // Mealy enable: a breakpoint blocks the matching instruction this cycle.
    assign cpu_en = ((state_q == RUN) & ~bp_hit) | (state_q == STEP);
    assign halted = (state_q == HALTED);

    // Next-state logic; halt beats a simultaneous continue edge in RUN.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        halt_event = 1'b0;
        case (state_q)
            RESET_HOLD: begin
                hold_cnt_d = hold_cnt_q + 8'd1;
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (halt_req_i || bp_hit) begin
                    state_d    = HALTED;
                    halt_event = 1'b1;
                end
            end
            HALTED: begin
                if (cont_rise) begin
                    state_d = step_mode_i ? STEP : RUN;
                end
            end
            STEP: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RESET_HOLD;
            end
        endcase
    end

    // Performance counters and halt PC capture; counters wrap freely.
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        halt_cnt_d  = halt_cnt_q;
        halt_pc_d   = halt_pc_q;
        if (cpu_en) begin
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        end
        if (halt_event) begin
            halt_cnt_d = halt_cnt_q + CNT_W'(1);
            halt_pc_d  = pc_i;
        end
    end

    // Debug source mux, registered below for one cycle of latency.
    always_comb begin
        debug_d = 32'b0;
        case (dbg_sel_i)
            DBG_CYCLES:   debug_d = 32'(cycle_cnt_q);
            DBG_HALT_PC:  debug_d = halt_pc_q;
            DBG_HALT_CNT: debug_d = 32'(halt_cnt_q);
            DBG_STATUS:   debug_d = status_word(bp_skip, halted, state_q);
            default:      debug_d = 32'b0;
        endcase
    end

    // State, counter and debug registers.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= RESET_HOLD;
            hold_cnt_q  <= 8'd0;
            cycle_cnt_q <= '0;
            halt_cnt_q  <= '0;
            halt_pc_q   <= 32'd0;
            debug_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            halt_cnt_q  <= halt_cnt_d;
            halt_pc_q   <= halt_pc_d;
            debug_q     <= debug_d;
        end
    end

    assign cpu_en_o = cpu_en;
    assign halted_o = halted;
    assign debug_o  = debug_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl (CNT_W=8, RESET_CYCLES=2). Stimulus
// pushes per-cycle expectations; a negedge monitor pops and compares them.
module tb_cpu_run_ctrl;

    logic        clk;
    logic        rst;
    logic        cont;
    logic        step_mode;
    logic        halt_req;
    logic [31:0] pc;
    logic [31:0] bp_addr;
    logic        bp_valid;
    logic [1:0]  dbg_sel;
    logic        cpu_en;
    logic        halted;
    logic [31:0] debug;

    cpu_run_ctrl #(
        .RESET_CYCLES (2),
        .CNT_W        (8)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .continue_i  (cont),
        .step_mode_i (step_mode),
        .halt_req_i  (halt_req),
        .pc_i        (pc),
        .bp_addr_i   (bp_addr),
        .bp_valid_i  (bp_valid),
        .dbg_sel_i   (dbg_sel),
        .cpu_en_o    (cpu_en),
        .halted_o    (halted),
        .debug_o     (debug)
    );

    localparam int SIG_EN  = 0;
    localparam int SIG_HLT = 1;
    localparam int SIG_DBG = 2;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation queued for the current cycle.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            case (e.sig)
                SIG_EN:  act = {31'b0, cpu_en};
                SIG_HLT: act = {31'b0, halted};
                default: act = debug;
            endcase
            checks++;
            if (act !== e.val) begin
                errors++;
                $display("FAIL %s (cycle %0d): got 0x%0h, want 0x%0h", e.name, cyc, act, e.val);
            end
        end
    end

    task automatic push_exp(input string name, input int sig, input logic [31:0] val);
        exp_t e;
        e.cyc  = cyc;
        e.sig  = sig;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; cont = 1'b0; step_mode = 1'b0; halt_req = 1'b0;
        pc = 32'd0; bp_addr = 32'd0; bp_valid = 1'b0; dbg_sel = 2'd0;
        tick(); tick();

        // Reset state, then release: cycle 0 of the hold window.
        push_exp("rst_cpu_en", SIG_EN, 0);
        push_exp("rst_halted", SIG_HLT, 0);
        push_exp("rst_debug", SIG_DBG, 0);
        rst = 1'b1;
        tick();
        push_exp("hold1_cpu_en", SIG_EN, 0);
        push_exp("hold1_debug", SIG_DBG, 0);
        tick();
        push_exp("run2_cpu_en", SIG_EN, 1);
        push_exp("run2_debug", SIG_DBG, 0);
        tick();
        push_exp("run3_cpu_en", SIG_EN, 1);
        push_exp("run3_debug", SIG_DBG, 0);
        tick();
        for (int k = 4; k <= 11; k++) begin
            push_exp("run_cpu_en", SIG_EN, 1);
            push_exp("run_cycles", SIG_DBG, 32'(k - 3));
            tick();
        end

        // HALT at pc 0x40 after 10 enabled cycles; halt_req held one more
        // cycle into HALTED, where it must be ignored.
        halt_req = 1'b1; pc = 32'h40;
        push_exp("halt_cyc_cpu_en", SIG_EN, 1);
        push_exp("halt_cyc_halted", SIG_HLT, 0);
        tick();
        pc = 32'd0; dbg_sel = 2'd1;
        push_exp("halted_after_req", SIG_HLT, 1);
        push_exp("cpu_en_after_req", SIG_EN, 0);
        push_exp("cycles_lag", SIG_DBG, 10);
        tick();
        halt_req = 1'b0; dbg_sel = 2'd2;
        push_exp("halt_pc_0x40", SIG_DBG, 32'h40);
        tick();
        dbg_sel = 2'd3;
        push_exp("halt_cnt_1", SIG_DBG, 1);
        tick();
        dbg_sel = 2'd0;
        push_exp("status_halted", SIG_DBG, 32'h6);
        tick();
        push_exp("cycles_11", SIG_DBG, 11);

        // Three single steps; halt_req during STEP must not count as a halt.
        for (int i = 0; i < 3; i++) begin
            cont = 1'b1; step_mode = 1'b1;
            push_exp("step_pre_halted", SIG_HLT, 1);
            push_exp("step_pre_cpu_en", SIG_EN, 0);
            tick();
            cont = 1'b0; halt_req = 1'b1;
            push_exp("step_cpu_en", SIG_EN, 1);
            push_exp("step_halted", SIG_HLT, 0);
            tick();
            halt_req = 1'b0;
            push_exp("step_post_cpu_en", SIG_EN, 0);
            push_exp("step_post_halted", SIG_HLT, 1);
            tick();
        end
        step_mode = 1'b0;
        push_exp("cycles_after_steps", SIG_DBG, 14);
        dbg_sel = 2'd2;
        tick();
        push_exp("halt_cnt_after_steps", SIG_DBG, 1);
        dbg_sel = 2'd0;
        tick();

        // Free-run resume, then halt_req and a continue edge together.
        cont = 1'b1;
        tick();
        cont = 1'b0;
        push_exp("resume_cpu_en", SIG_EN, 1);
        push_exp("resume_halted", SIG_HLT, 0);
        tick();
        halt_req = 1'b1; cont = 1'b1;
        push_exp("race_cpu_en", SIG_EN, 1);
        tick();
        halt_req = 1'b0;
        push_exp("race_halted", SIG_HLT, 1);
        push_exp("race_cpu_en_off", SIG_EN, 0);
        tick();
        cont = 1'b0;
        push_exp("race_no_resume", SIG_EN, 0);
        push_exp("race_still_halted", SIG_HLT, 1);
        tick();

        // Breakpoint at 0x20.
        bp_addr = 32'h20; bp_valid = 1'b1;
        cont = 1'b1;
        tick();
        cont = 1'b0; pc = 32'h10;
        push_exp("bp_pre_cpu_en", SIG_EN, 1);
        tick();
        pc = 32'h20;
`ifdef RUN_CTRL_BREAKPOINT_EN
        push_exp("bp_hit_cpu_en", SIG_EN, 0);
        push_exp("bp_hit_halted", SIG_HLT, 0);
        tick();
        dbg_sel = 2'd1;
        push_exp("bp_halted", SIG_HLT, 1);
        push_exp("bp_halted_cpu_en", SIG_EN, 0);
        tick();
        dbg_sel = 2'd0; cont = 1'b1;
        push_exp("bp_halt_pc", SIG_DBG, 32'h20);
        tick();
        cont = 1'b0;
        push_exp("bp_skip_cpu_en", SIG_EN, 1);
        push_exp("bp_skip_halted", SIG_HLT, 0);
        tick();
        pc = 32'h24;
        push_exp("bp_next_cpu_en", SIG_EN, 1);
        tick();
        pc = 32'h20;
        push_exp("bp_rehit_cpu_en", SIG_EN, 0);
        tick();
        push_exp("bp_rehit_halted", SIG_HLT, 1);
        bp_valid = 1'b0; pc = 32'd0;
        tick();
`else
        push_exp("nobp_cpu_en", SIG_EN, 1);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0; pc = 32'd0; dbg_sel = 2'd1;
        push_exp("nobp_halted", SIG_HLT, 1);
        tick();
        dbg_sel = 2'd0; bp_valid = 1'b0;
        push_exp("nobp_halt_pc", SIG_DBG, 32'h20);
        tick();
`endif

        // Free-run, then reset mid-RUN with continue held high throughout.
        cont = 1'b1;
        tick();
        push_exp("prerst_cpu_en", SIG_EN, 1);
        rst = 1'b0;
        tick();
        push_exp("midrst_cpu_en", SIG_EN, 0);
        push_exp("midrst_halted", SIG_HLT, 0);
        push_exp("midrst_debug", SIG_DBG, 0);
        rst = 1'b1;
        tick();
        push_exp("rehold_cpu_en", SIG_EN, 0);
        tick();

        // 256 enabled cycles with an 8-bit counter, halting on the last.
        for (int k = 0; k < 256; k++) begin
            push_exp("wrap_run_cpu_en", SIG_EN, 1);
            if (k == 0)   push_exp("wrap_first_debug", SIG_DBG, 0);
            if (k == 255) begin
                push_exp("wrap_254", SIG_DBG, 254);
                halt_req = 1'b1;
            end
            tick();
        end
        halt_req = 1'b0;
        push_exp("wrap_halted", SIG_HLT, 1);
        push_exp("wrap_cpu_en", SIG_EN, 0);
        push_exp("wrap_255", SIG_DBG, 255);
        tick();
        push_exp("wrap_zero", SIG_DBG, 0);
        push_exp("held_cont_no_resume", SIG_EN, 0);
        tick();
        cont = 1'b0;
        push_exp("held_cont_no_resume2", SIG_EN, 0);
        tick();
        cont = 1'b1;
        tick();
        cont = 1'b0; halt_req = 1'b1;
        push_exp("fresh_edge_resume", SIG_EN, 1);
        tick();
        halt_req = 1'b0;
        push_exp("final_halted", SIG_HLT, 1);
        tick();
        tick();

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run-control sequencer for the CPU core. It gates the core's single advance enable, holds the core idle for a fixed number of cycles after reset, and stops the core on a HALT instruction or an optional PC breakpoint. It resumes the core on a rising edge of the `continue` button, either in free-run mode or for a single step. It also owns the performance/debug counters and drives the 32-bit `debug` bus exported at CPU top level.

## Interface
- `RESET_CYCLES`, default 2: number of cycles `cpu_en` stays low after reset release; legal range 1..255.
- `CNT_W`, default 32: width of the cycle and halt counters; legal range 8..32.
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `rst`, input, 1: reset, synchronous and active-low; sampled on the `clk` rising edge.
- `continue`, input, 1: run/step request level, already synchronous to `clk`; only its rising edge is used.
- `step_mode`, input, 1: sampled on the `continue` rising edge; 1 = execute one instruction, 0 = free-run.
- `halt_req`, input, 1: decode asserts it while the HALT instruction is executing; honoured only when `cpu_en`=1.
- `pc`, input, 32: current core PC.
- `bp_addr`, input, 32: breakpoint address (used only with `RUN_CTRL_BREAKPOINT_EN`).
- `bp_valid`, input, 1: breakpoint armed.
- `dbg_sel`, input, 2: `debug` source select.
- `cpu_en`, output, 1: core commits state this cycle when 1.
- `halted`, output, 1: state is HALTED.
- `debug`, output, 32: selected debug word.

## Operation
- States (2-bit encoding):
  - RESET_HOLD = 0
  - RUN = 1
  - HALTED = 2
  - STEP = 3
- `cont_rise` = `continue` & ~`continue_q`. `continue_q` resets to 1, so a button already held through reset does not resume the core.
- `bp_hit` = `bp_valid` & (`pc` == `bp_addr`) & ~`bp_skip`.
- `cpu_en` = (state==RUN & ~`bp_hit`) | (state==STEP). This is a Mealy output, so a breakpoint suppresses execution of the matching instruction in the same cycle.
- Transitions:
  - RESET_HOLD → RUN when `hold_cnt` == `RESET_CYCLES`-1. `hold_cnt` increments each cycle in RESET_HOLD.
  - RUN → HALTED on `halt_req` (the HALT instruction completes in that cycle) or on `bp_hit`.
  - HALTED → STEP on `cont_rise` & `step_mode`.
  - HALTED → RUN on `cont_rise` & ~`step_mode`.
  - STEP → HALTED unconditionally after one cycle, whatever the value of `halt_req`.
- `bp_skip` is set on every exit from HALTED and cleared on the first cycle with `cpu_en`=1. This lets the core resume from a breakpoint PC without re-hitting it.
- `halt_pc` captures `pc` on each RUN→HALTED transition.
- `halt_cnt` increments on each RUN→HALTED transition.
- `cycle_cnt` increments on every cycle with `cpu_en`=1.
- Both counters wrap modulo 2^`CNT_W` without saturating. Each is zero-extended to 32 bits for `debug`.
- `debug` is a registered mux with one cycle of latency from `dbg_sel`:
  - 0: `cycle_cnt`
  - 1: `halt_pc`
  - 2: `halt_cnt`
  - 3: {28'b0, `bp_skip`, `halted`, state}
- Simultaneous events:
  - RUN with `halt_req` and `cont_rise` together: halt wins; `cont_rise` is ignored.
  - `halt_req` in HALTED or RESET_HOLD: ignored.
  - `cont_rise` in RUN, STEP or RESET_HOLD: ignored; no request is queued.
- Reset values:
  - state = RESET_HOLD
  - `cpu_en` = 0
  - `halted` = 0
  - `hold_cnt` = 0
  - `cycle_cnt` = 0
  - `halt_cnt` = 0
  - `halt_pc` = 0
  - `bp_skip` = 0
  - `debug` = 0
  - `continue_q` = 1
- Reset mid-operation: `rst`=0 in any state forces all of the above on the next edge.

## Timing
- Core starts executing on cycle `RESET_CYCLES` after the first edge with `rst`=1.
- `halt_req` at edge N: `halted`=1 and `cpu_en`=0 from cycle N+1 onward.
- `bp_hit` at cycle N: `cpu_en`=0 in cycle N (combinational) and `halted`=1 from cycle N+1.
- `continue` rising at edge N in HALTED: `cpu_en`=1 in cycle N+1.
- STEP: exactly one cycle with `cpu_en`=1, then `halted`=1.
- `debug` lags both its source and `dbg_sel` by one cycle.

## Configuration
- Macro: `RUN_CTRL_BREAKPOINT_EN`.
- Defined: the comparator and `bp_skip` logic are present, and `bp_hit` behaves as specified above.
- Undefined: `bp_hit` is tied to 0 and `bp_skip` reads as 0. The `bp_addr` and `bp_valid` ports remain on the module but are unused.

## Structure
- Shared package `cpu_ctrl_pkg` holds:
  - the `run_state_t` enum (RESET_HOLD, RUN, HALTED, STEP);
  - the `dbg_sel` encodings DBG_CYCLES, DBG_HALT_PC, DBG_HALT_CNT, DBG_STATUS.
- Sub-module `rise_detect` provides the registered edge detector for `continue`. Its reset value is a parameter, set to 1 here.
- The counters, FSM and debug mux stay inline in this block.

## Test plan
- Reset release with `RESET_CYCLES`=2: `cpu_en`=0 for cycles 0–1 and 1 from cycle 2; `debug` (sel 0) reads 0 until cycle 3.
- `halt_req` pulse with `pc`=0x40 after 10 enabled cycles:
  - `halted`=1 on the next cycle;
  - sel 1 reads 0x40;
  - sel 2 reads 1;
  - sel 0 reads 11.
- In HALTED with `step_mode`=1, three `continue` pulses: exactly 3 cycles with `cpu_en`=1, each followed by HALTED; `cycle_cnt` rises by 3.
- Breakpoint with `bp_addr`=0x20 and `bp_valid`=1, `pc` reaching 0x20:
  - `cpu_en`=0 in the same cycle and `halt_pc`=0x20;
  - after a `continue` rise, `cpu_en`=1 for `pc`=0x20 with no re-hit;
  - the next pass through 0x20 halts again.
- `halt_req` and `continue` rising together in RUN → HALTED; `continue` held high through `rst`=0 → no resume after RESET_HOLD without a fresh rising edge.
- `CNT_W`=8 with 256 enabled cycles → `cycle_cnt` wraps to 0; `rst`=0 asserted mid-RUN → all outputs return to reset values on the next edge.
